// File: rtl/temperature_calculator.sv
// temperature_calculator: temperature = factoryBaseTemp + factoryTempCoef * tempSensorValue
// using a 4-step shift-add multiplier followed by a registered 9-bit add.
//
// Ports:
//   clk, rst (async, active-high)
//   start                          - request, sampled only while idle
//   factoryBaseTemp[7:0]           - offset, captured on accepted start
//   factoryTempCoef[3:0]           - gain, captured on accepted start
//   tempSensorValue[3:0]           - reading, captured on accepted start
//   temperature[7:0]               - result, held until the next done
//   done                           - one-cycle pulse when temperature updates
//   busy                           - high from capture edge until done edge
//   overflow                       - 1 when the 9-bit sum exceeded 255
//
// Build option: TEMP_CALC_SATURATE_EN clamps an overflowing result to 8'hFF
// instead of wrapping modulo 256.

module temperature_calculator (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] factoryBaseTemp,
    input  logic [3:0] factoryTempCoef,
    input  logic [3:0] tempSensorValue,
    output logic [7:0] temperature,
    output logic       done,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } calcState_t;

    calcState_t state;
    calcState_t stateNext;

    logic [7:0] baseReg;
    logic [3:0] coefReg;
    logic [3:0] sensorReg;
    logic [7:0] product;
    logic [1:0] step;
    logic [8:0] sum9;
    logic [7:0] result;
    logic [7:0] partial;

    assign sum9    = {1'b0, baseReg} + {1'b0, product};
    assign partial = {4'b0000, sensorReg} << step;

`ifdef TEMP_CALC_SATURATE_EN
    assign result = sum9[8] ? 8'hFF : sum9[7:0];
`else
    assign result = sum9[7:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = MUL;
                end
            end
            MUL: begin
                if (step == 2'd3) begin
                    stateNext = ADD;
                end
            end
            ADD: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath; step wraps back to 0 after the last multiply bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baseReg     <= '0;
            coefReg     <= '0;
            sensorReg   <= '0;
            product     <= '0;
            step        <= '0;
            temperature <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        baseReg   <= factoryBaseTemp;
                        coefReg   <= factoryTempCoef;
                        sensorReg <= tempSensorValue;
                        product   <= '0;
                        step      <= '0;
                        busy      <= 1'b1;
                    end
                end
                MUL: begin
                    if (coefReg[step]) begin
                        product <= product + partial;
                    end
                    step <= step + 2'd1;
                end
                ADD: begin
                    temperature <= result;
                    overflow    <= sum9[8];
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temperature_calculator.sv
// tb_temperature_calculator: directed vectors against a latency-level model
// of temperature_calculator, compared on every falling edge.

module tb_temperature_calculator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] factoryBaseTemp;
    logic [3:0] factoryTempCoef;
    logic [3:0] tempSensorValue;
    logic [7:0] temperature;
    logic       done;
    logic       busy;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    temperature_calculator dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .factoryBaseTemp (factoryBaseTemp),
        .factoryTempCoef (factoryTempCoef),
        .tempSensorValue (tempSensorValue),
        .temperature     (temperature),
        .done            (done),
        .busy            (busy),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: result is plain arithmetic, delivered 5 edges after capture.
    bit       mBusy    = 1'b0;
    bit       mDone    = 1'b0;
    bit       mOvf     = 1'b0;
    bit       pendOvf  = 1'b0;
    int       mTemp    = 0;
    int       pendTemp = 0;
    int       rem      = 0;

    function automatic int expectedTemp(int b, int c, int s);
        int sum;
        sum = b + c * s;
`ifdef TEMP_CALC_SATURATE_EN
        if (sum > 255) return 255;
        return sum;
`else
        return sum % 256;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy = 1'b0;
            mDone = 1'b0;
            mTemp = 0;
            mOvf  = 1'b0;
            rem   = 0;
        end else begin
            mDone = 1'b0;
            if (mBusy) begin
                rem = rem - 1;
                if (rem == 0) begin
                    mBusy = 1'b0;
                    mDone = 1'b1;
                    mTemp = pendTemp;
                    mOvf  = pendOvf;
                end
            end else if (start) begin
                pendTemp = expectedTemp(int'(factoryBaseTemp),
                    int'(factoryTempCoef), int'(tempSensorValue));
                pendOvf  = (int'(factoryBaseTemp) +
                    int'(factoryTempCoef) * int'(tempSensorValue)) > 255;
                mBusy    = 1'b1;
                rem      = 5;
            end
        end
    end

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("temperature", int'(temperature), mTemp);
            check("done", int'(done), int'(mDone));
            check("busy", int'(busy), int'(mBusy));
            check("overflow", int'(overflow), int'(mOvf));
        end
    end

    task automatic startOp(input logic [7:0] b, input logic [3:0] c,
                           input logic [3:0] s);
        @(posedge clk);
        #1;
        factoryBaseTemp = b;
        factoryTempCoef = c;
        tempSensorValue = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of edges after capture at which done appeared.
    task automatic waitDone(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy) busyCycles++;
            if (done) begin
                lat = n - 1;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic idle(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    int lat;
    int bc;
    int dn;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        factoryBaseTemp = '0;
        factoryTempCoef = '0;
        tempSensorValue = '0;
        repeat (2) @(posedge clk);
        checkEn = 1'b1;
        @(negedge clk);
        check("reset_temperature", int'(temperature), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: 0 + 5*1
        startOp(8'd0, 4'd5, 4'd1);
        waitDone(lat, bc);
        check("t1_latency", lat, 5);
        check("t1_temperature", int'(temperature), 5);
        check("t1_model", mTemp, 5);
        check("t1_overflow", int'(overflow), 0);

        // 2: 20 + 3*4, busy for 5 cycles
        startOp(8'd20, 4'd3, 4'd4);
        waitDone(lat, bc);
        check("t2_temperature", int'(temperature), 32);
        check("t2_busy_cycles", bc, 5);

        // 3: 255 + 15*15 = 480
        startOp(8'd255, 4'd15, 4'd15);
        waitDone(lat, bc);
        check("t3_overflow", int'(overflow), 1);
`ifdef TEMP_CALC_SATURATE_EN
        check("t3_temperature", int'(temperature), 255);
`else
        check("t3_temperature", int'(temperature), 224);
`endif

        // back-to-back: start at the edge right after done
        @(posedge clk);
        #1;
        factoryBaseTemp = 8'd7;
        factoryTempCoef = 4'd2;
        tempSensorValue = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, bc);
        check("b2b_temperature", int'(temperature), 13);

        // 4: second start 2 cycles into a run is ignored
        startOp(8'd10, 4'd2, 4'd2);
        repeat (2) @(posedge clk);
        #1;
        factoryBaseTemp = 8'd200;
        factoryTempCoef = 4'd9;
        tempSensorValue = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(12, dn);
        check("t4_done_pulses", dn, 1);
        check("t4_temperature", int'(temperature), 14);

        // 5: reset during MUL
        startOp(8'd50, 4'd4, 4'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2, dn);
        check("t5_temperature", int'(temperature), 0);
        check("t5_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8, dn);
        check("t5_no_done", dn, 0);
        startOp(8'd1, 4'd6, 4'd7);
        waitDone(lat, bc);
        check("t5_restart_temperature", int'(temperature), 43);

        // 6: coef=0 then long idle
        startOp(8'd100, 4'd0, 4'd9);
        waitDone(lat, bc);
        check("t6_temperature", int'(temperature), 100);
        check("t6_overflow", int'(overflow), 0);
        idle(10, dn);
        check("t6_idle_dones", dn, 0);
        check("t6_held", int'(temperature), 100);

        // sensor=0 case
        startOp(8'd77, 4'd11, 4'd0);
        waitDone(lat, bc);
        check("s0_temperature", int'(temperature), 77);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
